// File: rtl/lcd_char_driver_pkg.sv
// Shared definitions for the LCD character driver.
//   - state encodings for the sequencing FSM and the nibble strobe
//   - LCD configuration bytes sent after power-on
//   - default timing counts (clock cycles at 50 MHz)
//   - small helpers for counter loads and init tables
package lcd_char_driver_pkg;

    localparam int unsigned CNT_W = 20;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam int unsigned DEF_PWRON = 750000;
    localparam int unsigned DEF_INIT1 = 205000;
    localparam int unsigned DEF_INIT2 = 5000;
    localparam int unsigned DEF_SHORT = 2000;
    localparam int unsigned DEF_CLEAR = 82000;
    localparam int unsigned DEF_GAP   = 50;
    localparam int unsigned DEF_SETUP = 2;
    localparam int unsigned DEF_PULSE = 12;
    localparam int unsigned DEF_HOLD  = 1;

    localparam logic [7:0] INIT_FUNC  = 8'h28;  // 4-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] INIT_ENTRY = 8'h06;  // increment, no shift
    localparam logic [7:0] INIT_DISP  = 8'h0C;  // display on, cursor off
    localparam logic [7:0] INIT_CLEAR = 8'h01;  // clear display

    typedef enum logic [2:0] {
        ST_PWRON,
        ST_INIT_NIB,
        ST_INIT_WAIT,
        ST_HI,
        ST_GAP,
        ST_LO,
        ST_POST,
        ST_IDLE
    } drv_state_t;

    typedef enum logic [1:0] {
        NS_IDLE,
        NS_SETUP,
        NS_PULSE,
        NS_HOLD
    } strobe_state_t;

    // A state lasting N cycles loads N-1; zero is clamped to a single cycle.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        if (cycles == 0)
            return '0;
        return CNT_W'(cycles - 1);
    endfunction

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    return INIT_FUNC;
            2'd1:    return INIT_ENTRY;
            2'd2:    return INIT_DISP;
            default: return INIT_CLEAR;
        endcase
    endfunction

    // Lone wake-up nibbles: 0x3, 0x3, 0x3, then 0x2 to enter 4-bit mode.
    function automatic logic [3:0] init_nibble(input logic [1:0] i);
        return (i == 2'd3) ? 4'h2 : 4'h3;
    endfunction

    // Clear and home commands need the long post-byte wait.
    function automatic logic needs_clear(input logic rs, input logic [7:0] d);
        return !rs && (d != 8'h00) && (d <= 8'h03);
    endfunction

endpackage

// File: rtl/lcd_char_driver_if.sv
// CPU-side handshake for the LCD driver.
//   iWrite    request, sampled only while oReady=1
//   iRS       0 = command byte, 1 = character data
//   iData     byte to send
//   oReady    idle and initialised, next request will be accepted
//   oInitDone sticky once the configuration sequence completes
interface lcd_char_driver_if;
    logic       iWrite;
    logic       iRS;
    logic [7:0] iData;
    logic       oReady;
    logic       oInitDone;

    modport master (output iWrite, output iRS, output iData,
                    input oReady, input oInitDone);
    modport slave  (input iWrite, input iRS, input iData,
                    output oReady, output oInitDone);
endinterface

// File: rtl/lcd_char_driver_strobe.sv
// lcd_nibble_strobe: drives one nibble onto the LCD bus.
//   start       begin a nibble (ignored unless idle)
//   nibble, rs  latched on start, held on lcd_d/lcd_rs until the next start
//   lcd_e       enable strobe: SETUP (E=0), PULSE (E=1), HOLD (E=0)
//   done        high during the last HOLD cycle
module lcd_nibble_strobe
    import lcd_char_driver_pkg::*;
#(
    parameter int unsigned P_SETUP = DEF_SETUP,
    parameter int unsigned P_PULSE = DEF_PULSE,
    parameter int unsigned P_HOLD  = DEF_HOLD
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       start,
    input  logic [3:0] nibble,
    input  logic       rs,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic [3:0] lcd_d,
    output logic       done
);

    strobe_state_t    state;
    logic [CNT_W-1:0] cnt;

    // Combinational so the sequencer can move on in the same edge HOLD ends.
    assign done = (state == NS_HOLD) && (cnt == '0);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state  <= NS_IDLE;
            cnt    <= '0;
            lcd_e  <= 1'b0;
            lcd_rs <= 1'b0;
            lcd_d  <= '0;
        end else begin
            case (state)
                NS_IDLE: begin
                    if (start) begin
                        lcd_d  <= nibble;
                        lcd_rs <= rs;
                        cnt    <= cnt_load(P_SETUP);
                        state  <= NS_SETUP;
                    end
                end
                NS_SETUP: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b1;
                        cnt   <= cnt_load(P_PULSE);
                        state <= NS_PULSE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                NS_PULSE: begin
                    if (cnt == '0) begin
                        lcd_e <= 1'b0;
                        cnt   <= cnt_load(P_HOLD);
                        state <= NS_HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                NS_HOLD: begin
                    if (cnt == '0)
                        state <= NS_IDLE;
                    else
                        cnt <= cnt - CNT_ONE;
                end
                default: state <= NS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_char_driver.sv
// lcd_char_driver: byte-wide front end for the Spartan-3E 16x2 character LCD.
//   Clock, Reset  50 MHz clock, synchronous active-high reset
//   cpu           handshake (iWrite/iRS/iData in, oReady/oInitDone out)
//   oLCD_E        enable strobe
//   oLCD_RS       register select
//   oLCD_RW       always 0 (write only)
//   oSF_D         data nibble (SF_D[11:8])
// After reset the power-on wait, wake-up nibbles and configuration bytes run
// automatically; afterwards each accepted byte goes out high nibble first.
module lcd_char_driver
    import lcd_char_driver_pkg::*;
#(
    parameter int unsigned P_PWRON = DEF_PWRON,
    parameter int unsigned P_INIT1 = DEF_INIT1,
    parameter int unsigned P_INIT2 = DEF_INIT2,
    parameter int unsigned P_SHORT = DEF_SHORT,
    parameter int unsigned P_CLEAR = DEF_CLEAR,
    parameter int unsigned P_GAP   = DEF_GAP,
    parameter int unsigned P_SETUP = DEF_SETUP,
    parameter int unsigned P_PULSE = DEF_PULSE,
    parameter int unsigned P_HOLD  = DEF_HOLD
) (
    input  logic                     Clock,
    input  logic                     Reset,
    lcd_char_driver_if.slave         cpu,
    output logic                     oLCD_E,
    output logic                     oLCD_RS,
    output logic                     oLCD_RW,
    output logic [3:0]               oSF_D
);

    drv_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;        // wake-up nibble index, then init byte index
    logic             in_init;
    logic [7:0]       byte_q;
    logic             rs_q;
    logic             start;
    logic [3:0]       nib;
    logic             ready;
    logic             init_done;
    logic             strobe_done;
    logic [7:0]       next_init;

    always_comb begin
        next_init = init_byte(idx + 2'd1);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ST_PWRON;
            cnt       <= cnt_load(P_PWRON);
            idx       <= '0;
            in_init   <= 1'b1;
            byte_q    <= '0;
            rs_q      <= 1'b0;
            start     <= 1'b0;
            nib       <= '0;
            ready     <= 1'b0;
            init_done <= 1'b0;
        end else begin
            start <= 1'b0;
            case (state)
                ST_PWRON: begin
                    if (cnt == '0) begin
                        start <= 1'b1;
                        nib   <= init_nibble(2'd0);
                        rs_q  <= 1'b0;
                        idx   <= '0;
                        state <= ST_INIT_NIB;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_INIT_NIB: begin
                    if (strobe_done) begin
                        case (idx)
                            2'd0:    cnt <= cnt_load(P_INIT1);
                            2'd1:    cnt <= cnt_load(P_INIT2);
                            default: cnt <= cnt_load(P_SHORT);
                        endcase
                        state <= ST_INIT_WAIT;
                    end
                end
                ST_INIT_WAIT: begin
                    if (cnt == '0) begin
                        start <= 1'b1;
                        if (idx == 2'd3) begin
                            // Wake-up done; configuration bytes reuse the user byte path.
                            idx    <= '0;
                            byte_q <= INIT_FUNC;
                            rs_q   <= 1'b0;
                            nib    <= INIT_FUNC[7:4];
                            state  <= ST_HI;
                        end else begin
                            idx   <= idx + 2'd1;
                            nib   <= init_nibble(idx + 2'd1);
                            state <= ST_INIT_NIB;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_HI: begin
                    if (strobe_done) begin
                        cnt   <= cnt_load(P_GAP);
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        start <= 1'b1;
                        nib   <= byte_q[3:0];
                        state <= ST_LO;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_LO: begin
                    if (strobe_done) begin
                        cnt   <= needs_clear(rs_q, byte_q) ? cnt_load(P_CLEAR)
                                                           : cnt_load(P_SHORT);
                        state <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (cnt == '0) begin
                        if (in_init && (idx != 2'd3)) begin
                            idx    <= idx + 2'd1;
                            byte_q <= next_init;
                            rs_q   <= 1'b0;
                            nib    <= next_init[7:4];
                            start  <= 1'b1;
                            state  <= ST_HI;
                        end else begin
                            in_init   <= 1'b0;
                            init_done <= 1'b1;
                            ready     <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    if (cpu.iWrite) begin
                        byte_q <= cpu.iData;
                        rs_q   <= cpu.iRS;
                        nib    <= cpu.iData[7:4];
                        start  <= 1'b1;
                        ready  <= 1'b0;
                        state  <= ST_HI;
                    end
                end
                default: state <= ST_PWRON;
            endcase
        end
    end

    lcd_nibble_strobe #(
        .P_SETUP (P_SETUP),
        .P_PULSE (P_PULSE),
        .P_HOLD  (P_HOLD)
    ) u_strobe (
        .Clock  (Clock),
        .Reset  (Reset),
        .start  (start),
        .nibble (nib),
        .rs     (rs_q),
        .lcd_e  (oLCD_E),
        .lcd_rs (oLCD_RS),
        .lcd_d  (oSF_D),
        .done   (strobe_done)
    );

    assign cpu.oReady    = ready;
    assign cpu.oInitDone = init_done;
    assign oLCD_RW       = 1'b0;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Directed bench for lcd_char_driver with shortened timing.
module tb_lcd_char_driver;

    localparam int PWRON = 20;
    localparam int INIT1 = 10;
    localparam int INIT2 = 7;
    localparam int SHORT = 5;
    localparam int CLEAR = 15;
    localparam int GAP   = 3;
    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       oLCD_E, oLCD_RS, oLCD_RW;
    logic [3:0] oSF_D;

    lcd_char_driver_if cpu();

    lcd_char_driver #(
        .P_PWRON (PWRON), .P_INIT1 (INIT1), .P_INIT2 (INIT2),
        .P_SHORT (SHORT), .P_CLEAR (CLEAR), .P_GAP (GAP),
        .P_SETUP (SETUP), .P_PULSE (PULSE), .P_HOLD (HOLD)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .cpu     (cpu),
        .oLCD_E  (oLCD_E),
        .oLCD_RS (oLCD_RS),
        .oLCD_RW (oLCD_RW),
        .oSF_D   (oSF_D)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    // Bus monitor: records every E pulse (nibble, RS, rise/fall cycle).
    logic [3:0] mon_nib[$];
    logic       mon_rs[$];
    int         rise_q[$];
    int         fall_q[$];
    int         ready_rise = -1;
    int         done_rise  = -1;
    int         unstable   = 0;
    logic       e_prev = 1'b0, r_prev = 1'b0, d_prev = 1'b0;
    logic [3:0] cur_nib = '0;
    logic       cur_rs  = 1'b0;

    always @(negedge Clock) begin
        if (oLCD_E && !e_prev) begin
            mon_nib.push_back(oSF_D);
            mon_rs.push_back(oLCD_RS);
            rise_q.push_back(cyc);
            cur_nib <= oSF_D;
            cur_rs  <= oLCD_RS;
        end
        if (oLCD_E && e_prev && (oSF_D !== cur_nib || oLCD_RS !== cur_rs))
            unstable <= unstable + 1;
        if (!oLCD_E && e_prev)
            fall_q.push_back(cyc);
        if (cpu.oReady && !r_prev)
            ready_rise <= cyc;
        if (cpu.oInitDone && !d_prev)
            done_rise <= cyc;
        e_prev <= oLCD_E;
        r_prev <= cpu.oReady;
        d_prev <= cpu.oInitDone;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_mon();
        mon_nib.delete();
        mon_rs.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (cpu.oReady !== 1'b1 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        #1;
        chk({tag, "_ready_timeout"}, int'(cpu.oReady === 1'b1), 1);
    endtask

    task automatic wait_init(input string tag, input int budget);
        int n = 0;
        while (cpu.oInitDone !== 1'b1 && n < budget) begin
            @(negedge Clock);
            n++;
        end
        #1;
        chk({tag, "_initdone"}, int'(cpu.oInitDone === 1'b1), 1);
        chk({tag, "_ready"}, int'(cpu.oReady === 1'b1), 1);
    endtask

    // rel = cycle stamp at the negedge following the last reset edge.
    task automatic check_init(input string tag, input int rel);
        logic [3:0] exp_nib[12];
        int         exp_wait[12];
        logic       rs_any = 1'b0;
        exp_nib  = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};
        exp_wait = '{0, INIT1, INIT2, SHORT, SHORT, GAP, SHORT, GAP, SHORT, GAP, SHORT, GAP};
        chk({tag, "_npulse"}, mon_nib.size(), 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("%s_nib%0d", tag, i), int'(mon_nib[i]), int'(exp_nib[i]));
            chk($sformatf("%s_width%0d", tag, i), fall_q[i] - rise_q[i], PULSE);
            rs_any = rs_any | mon_rs[i];
            // Low time: HOLD, the wait itself, one cycle to restart the strobe, SETUP.
            if (i > 0)
                chk($sformatf("%s_low%0d", tag, i), rise_q[i] - fall_q[i-1],
                    HOLD + exp_wait[i] + 1 + SETUP);
        end
        chk({tag, "_rs0"}, int'(rs_any), 0);
        chk({tag, "_first_rise"}, rise_q[0] - rel, PWRON + 1 + SETUP);
        chk({tag, "_ready_with_done"}, ready_rise, done_rise);
        chk({tag, "_clear_wait"}, done_rise - fall_q[11], HOLD + CLEAR);
    endtask

    task automatic send(input logic rs, input logic [7:0] d, output int acc);
        wait_ready("send", 400);
        cpu.iWrite = 1'b1;
        cpu.iRS    = rs;
        cpu.iData  = d;
        @(negedge Clock);
        acc = cyc;
        cpu.iWrite = 1'b0;
        chk("accept_ready_low", int'(cpu.oReady), 0);
    endtask

    // Checks one byte at pulse slots base/base+1; w is the expected post-byte wait.
    task automatic check_byte(input string tag, input int base, input logic rs,
                              input logic [7:0] d, input int acc, input int w,
                              input logic chk_post);
        chk({tag, "_hi"}, int'(mon_nib[base]), int'(d[7:4]));
        chk({tag, "_lo"}, int'(mon_nib[base+1]), int'(d[3:0]));
        chk({tag, "_rs"}, int'({mon_rs[base], mon_rs[base+1]}), int'({rs, rs}));
        chk({tag, "_wid_hi"}, fall_q[base] - rise_q[base], PULSE);
        chk({tag, "_wid_lo"}, fall_q[base+1] - rise_q[base+1], PULSE);
        chk({tag, "_gap"}, rise_q[base+1] - fall_q[base], HOLD + GAP + 1 + SETUP);
        chk({tag, "_latency"}, rise_q[base] - acc, 1 + SETUP);
        if (chk_post)
            chk({tag, "_post"}, ready_rise - fall_q[base+1], HOLD + w);
    endtask

    logic       t_rs[6];
    logic [7:0] t_d[6];
    int         t_w[6];
    logic [7:0] msg[4];
    int         accs[4];
    int         acc, rel, n, rr;

    initial begin
        cpu.iWrite = 1'b0;
        cpu.iRS    = 1'b0;
        cpu.iData  = 8'h00;

        // T1: reset values, then the full init sequence
        repeat (3) @(negedge Clock);
        chk("rst_ready", int'(cpu.oReady), 0);
        chk("rst_initdone", int'(cpu.oInitDone), 0);
        chk("rst_e", int'(oLCD_E), 0);
        chk("rst_rs", int'(oLCD_RS), 0);
        chk("rst_rw", int'(oLCD_RW), 0);
        chk("rst_d", int'(oSF_D), 0);
        clear_mon();
        rel   = cyc;
        Reset = 1'b0;

        // T4a: requests during power-on are dropped
        repeat (8) @(negedge Clock);
        cpu.iWrite = 1'b1;
        cpu.iRS    = 1'b1;
        cpu.iData  = 8'hAA;
        repeat (4) @(negedge Clock);
        cpu.iWrite = 1'b0;
        wait_init("init", 2000);
        check_init("init", rel);

        // T2: character 'H'
        clear_mon();
        send(1'b1, 8'h48, acc);
        wait_ready("H", 400);
        chk("H_npulse", mon_nib.size(), 2);
        check_byte("H", 0, 1'b1, 8'h48, acc, SHORT, 1'b1);

        // T3: post-byte wait selection, incl. range edges
        t_rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        t_d  = '{8'h01, 8'h03, 8'h04, 8'h80, 8'h01, 8'h00};
        t_w  = '{CLEAR, CLEAR, SHORT, SHORT, SHORT, SHORT};
        for (int i = 0; i < 6; i++) begin
            clear_mon();
            send(t_rs[i], t_d[i], acc);
            wait_ready("post", 400);
            check_byte($sformatf("post%0d", i), 0, t_rs[i], t_d[i], acc, t_w[i], 1'b1);
        end

        // T4b: request mid-byte is ignored
        clear_mon();
        send(1'b1, 8'h5A, acc);
        repeat (10) @(negedge Clock);
        cpu.iWrite = 1'b1;
        cpu.iRS    = 1'b0;
        cpu.iData  = 8'hFF;
        @(negedge Clock);
        cpu.iWrite = 1'b0;
        wait_ready("mid", 400);
        check_byte("mid", 0, 1'b1, 8'h5A, acc, SHORT, 1'b1);
        repeat (30) @(negedge Clock);
        #1;
        chk("mid_npulse", mon_nib.size(), 2);

        // T5: iWrite held high, data stepping "Hola"
        clear_mon();
        msg = '{8'h48, 8'h6F, 8'h6C, 8'h61};
        cpu.iRS    = 1'b1;
        cpu.iData  = msg[0];
        cpu.iWrite = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_ready("b2b", 400);
            rr = ready_rise;
            @(negedge Clock);
            accs[i] = cyc;
            chk($sformatf("b2b_accept%0d", i), int'(cpu.oReady), 0);
            if (i > 0)
                chk($sformatf("b2b_first_ready%0d", i), accs[i] - rr, 1);
            if (i < 3)
                cpu.iData = msg[i+1];
            else
                cpu.iWrite = 1'b0;
        end
        wait_ready("b2b_end", 400);
        chk("b2b_npulse", mon_nib.size(), 8);
        for (int i = 0; i < 4; i++)
            check_byte($sformatf("b2b%0d", i), 2 * i, 1'b1, msg[i], accs[i], SHORT, 1'b0);

        // T6: reset asserted while E is high
        clear_mon();
        send(1'b1, 8'h48, acc);
        n = 0;
        while (oLCD_E !== 1'b1 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        chk("rst_mid_reach_e", int'(oLCD_E === 1'b1), 1);
        Reset = 1'b1;
        @(negedge Clock);
        chk("rst_mid_e", int'(oLCD_E), 0);
        chk("rst_mid_rs", int'(oLCD_RS), 0);
        chk("rst_mid_d", int'(oSF_D), 0);
        chk("rst_mid_ready", int'(cpu.oReady), 0);
        chk("rst_mid_initdone", int'(cpu.oInitDone), 0);
        @(negedge Clock);
        clear_mon();
        rel   = cyc;
        Reset = 1'b0;
        wait_init("reinit", 2000);
        check_init("reinit", rel);

        chk("data_stable_in_pulse", unstable, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
